// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file (clear FSM states, address width).
package reg_file_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Address width for a given entry count; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_file_param.sv
// DEPTH x WIDTH register file: one write port, two registered read ports, sequenced bulk clear.
// Optional macro RF_WR_BYPASS_EN makes a same-cycle read of the written address return wr_data.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_drop,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd0_addr,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd0_data,
    output logic [WIDTH-1:0] rd1_data,
    output logic             rd_valid
);

    localparam bit FULL_MAP = (DEPTH == (1 << AW));

    logic [WIDTH-1:0] mem [DEPTH];
    rf_state_e        state;
    logic [AW-1:0]    idx;

    logic             wr_in_range;
    logic             rd0_in_range;
    logic             rd1_in_range;
    logic             wr_accept;
    logic             rd_fire;
    logic [WIDTH-1:0] rd0_next;
    logic [WIDTH-1:0] rd1_next;

    // With a power-of-two depth every address is legal, so no compare is built.
    generate
        if (FULL_MAP) begin : g_full_map
            assign wr_in_range  = 1'b1;
            assign rd0_in_range = 1'b1;
            assign rd1_in_range = 1'b1;
        end else begin : g_part_map
            assign wr_in_range  = (wr_addr  < AW'(DEPTH));
            assign rd0_in_range = (rd0_addr < AW'(DEPTH));
            assign rd1_in_range = (rd1_addr < AW'(DEPTH));
        end
    endgenerate

    assign wr_accept = (state == RF_IDLE) && wr_en && !clr && wr_in_range;
    assign rd_fire   = (state == RF_IDLE) && rd_en;

    always_comb begin
        rd0_next = rd0_in_range ? mem[rd0_addr] : '0;
        rd1_next = rd1_in_range ? mem[rd1_addr] : '0;
`ifdef RF_WR_BYPASS_EN
        if (wr_accept && (rd0_addr == wr_addr)) rd0_next = wr_data;
        if (wr_accept && (rd1_addr == wr_addr)) rd1_next = wr_data;
`endif
    end

    // NOTE: the storage array is reset explicitly because reset must leave every entry at zero;
    // this forces flops rather than a RAM macro, which is acceptable at register-file sizes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RF_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr) begin
                        state <= RF_CLEAR;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end else if (wr_accept) begin
                        mem[wr_addr] <= wr_data;
                    end
                end
                RF_CLEAR: begin
                    mem[idx] <= '0;
                    if (idx == AW'(DEPTH - 1)) begin
                        state <= RF_IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= RF_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: non-blocking updates mean rd*_next sees the array as it was before this edge's
    // write, which is exactly the read-first behaviour when bypass is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd0_data <= '0;
            rd1_data <= '0;
            rd_valid <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            wr_drop  <= wr_en && !wr_accept;
            if (rd_fire) begin
                rd0_data <= rd0_next;
                rd1_data <= rd1_next;
            end
        end
    end

endmodule
